// File: rtl/counter_pkg.sv
// Shared widths and count types for the 3:2 / 7:3 population counters.
// The multiplier reduction tree imports these as well.
package counter_pkg;

  localparam int unsigned C32_IN_W  = 3;
  localparam int unsigned C32_OUT_W = 2;
  localparam int unsigned C73_IN_W  = 7;
  localparam int unsigned C73_OUT_W = 3;

  typedef logic [C32_IN_W-1:0]  c32_in_t;
  typedef logic [C32_OUT_W-1:0] c32_cnt_t;
  typedef logic [C73_IN_W-1:0]  c73_in_t;
  typedef logic [C73_OUT_W-1:0] c73_cnt_t;

endpackage

// File: rtl/counter_3_2.sv
// 3:2 counter (full adder): out[0] is the sum bit, out[1] the majority carry.
module counter_3_2
  import counter_pkg::*;
(
  input  logic [C32_IN_W-1:0]  in,
  output logic [C32_OUT_W-1:0] out
);

  always_comb begin
    out    = '0;
    out[0] = in[0] ^ in[1] ^ in[2];
    out[1] = (in[0] & in[1]) | (in[0] & in[2]) | (in[1] & in[2]);
  end

endmodule

// File: rtl/counter_7_3.sv
// 7:3 counter built from four full adders, three levels deep.
module counter_7_3
  import counter_pkg::*;
(
  input  logic [C73_IN_W-1:0]  in,
  output logic [C73_OUT_W-1:0] out
);

  c32_cnt_t fa1_out;
  c32_cnt_t fa2_out;
  c32_cnt_t fa3_out;
  c32_cnt_t fa4_out;

  counter_3_2 u_fa1 (
    .in  (in[2:0]),
    .out (fa1_out)
  );

  counter_3_2 u_fa2 (
    .in  (in[5:3]),
    .out (fa2_out)
  );

  // Weight-1 sums of both groups plus bit 6 give the final LSB.
  counter_3_2 u_fa3 (
    .in  ({in[6], fa2_out[0], fa1_out[0]}),
    .out (fa3_out)
  );

  // All three weight-2 carries compress into the upper two bits.
  counter_3_2 u_fa4 (
    .in  ({fa3_out[1], fa2_out[1], fa1_out[1]}),
    .out (fa4_out)
  );

  assign out = {fa4_out[1], fa4_out[0], fa3_out[0]};

endmodule

// File: rtl/counter_unit.sv
// Registered population-count unit: parallel 3:2 and 7:3 counters with one
// output register stage and a valid flag.
module counter_unit
  import counter_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [C32_IN_W-1:0]  in_3_2,
  input  logic [C73_IN_W-1:0]  in_7_3,
  output logic                 out_valid,
  output logic [C32_OUT_W-1:0] out_3_2,
  output logic [C73_OUT_W-1:0] out_7_3
);

  c32_cnt_t cnt_3_2;
  c73_cnt_t cnt_7_3;

  counter_3_2 u_c32 (
    .in  (in_3_2),
    .out (cnt_3_2)
  );

  counter_7_3 u_c73 (
    .in  (in_7_3),
    .out (cnt_7_3)
  );

  // Data registers hold across invalid cycles; only the valid flag drops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_3_2   <= '0;
      out_7_3   <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_3_2 <= cnt_3_2;
        out_7_3 <= cnt_7_3;
      end
    end
  end

endmodule

// File: tb/tb_counter_unit.sv
// Scoreboard bench for counter_unit: stimulus queues expected counts, a
// monitor pops and compares whenever out_valid is seen.
module tb_counter_unit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [2:0] in_3_2;
  logic [6:0] in_7_3;
  logic       out_valid;
  logic [1:0] out_3_2;
  logic [2:0] out_7_3;

  typedef struct {
    logic [1:0] e32;
    logic [2:0] e73;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  counter_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_3_2    (in_3_2),
    .in_7_3    (in_7_3),
    .out_valid (out_valid),
    .out_3_2   (out_3_2),
    .out_7_3   (out_7_3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int popcnt(input logic [6:0] v);
    int n = 0;
    for (int i = 0; i < 7; i++) if (v[i]) n++;
    return n;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  // Drive one valid pair for one cycle and queue its expected counts.
  task automatic drive(input logic [2:0] a, input logic [6:0] b, input logic [1:0] e32,
                       input logic [2:0] e73, input string nm);
    exp_t e;
    in_valid = 1'b1;
    in_3_2   = a;
    in_7_3   = b;
    e.e32 = e32;
    e.e73 = e73;
    e.name = nm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_valid: got out_valid 1 expected no output");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check({e.name, "_32"}, 32'(out_3_2), 32'(e.e32));
        check({e.name, "_73"}, 32'(out_7_3), 32'(e.e73));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] a;
    logic [6:0] b;
    rst      = 1'b0;
    in_valid = 1'b0;
    in_3_2   = '0;
    in_7_3   = '0;
    #1 rst = 1'b1;
    #2;
    check("reset_valid", 32'(out_valid), 0);
    check("reset_32", 32'(out_3_2), 0);
    check("reset_73", 32'(out_7_3), 0);
    #9 rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed vectors
    drive(3'b101, 7'b1010101, 2'b10, 3'b100, "dir_101");
    drive(3'b111, 7'b1111111, 2'b11, 3'b111, "dir_all1");
    drive(3'b000, 7'b0000000, 2'b00, 3'b000, "dir_all0");
    drive(3'b111, 7'b0000001, 2'b11, 3'b001, "independence");

    // Valid gating: data holds, valid drops
    drive(3'b010, 7'b0111111, 2'b01, 3'b110, "gate_load");
    in_7_3 = 7'b0;
    in_3_2 = 3'b0;
    idle();
    check("gate_valid", 32'(out_valid), 0);
    check("gate_hold_73", 32'(out_7_3), 6);
    check("gate_hold_32", 32'(out_3_2), 1);

    // Exhaustive sweeps
    for (int i = 0; i < 8; i++) begin
      a = 3'(i);
      drive(a, 7'b0, 2'(popcnt({4'b0, a})), 3'b000, "exh_32");
    end
    for (int i = 0; i < 128; i++) begin
      b = 7'(i);
      a = b[2:0];
      drive(a, b, 2'(popcnt({4'b0, a})), 3'(popcnt(b)), "exh_73");
    end

    // Mid-stream reset discards the in-flight 7'b1111111 and clears outputs at once
    drive(3'b011, 7'b1111111, 2'b10, 3'b111, "pre_rst");
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    check("rst_async_valid", 32'(out_valid), 0);
    check("rst_async_32", 32'(out_3_2), 0);
    check("rst_async_73", 32'(out_7_3), 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    #2 rst = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("post_rst_valid", 32'(out_valid), 0);
    check("post_rst_32", 32'(out_3_2), 0);
    check("post_rst_73", 32'(out_7_3), 0);

    // Back-to-back random stream; valid must stay high throughout
    for (int i = 0; i < 1000; i++) begin
      a = 3'($urandom);
      b = 7'($urandom);
      drive(a, b, 2'(popcnt({4'b0, a})), 3'(popcnt(b)), "stream");
      check("stream_valid", 32'(out_valid), 1);
    end

    idle();
    idle();
    idle();
    check("queue_drained", 32'(exp_q.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
